// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: round-robin 7-segment scan with per-slot blanking and frame-aligned update commit.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module seg_scan_scheduler #(
    parameter int NUM_DIGITS   = 3,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_tick
);
    localparam int TW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0] LAST_T  = TW'(PRESCALE - 1);
    localparam logic [TW-1:0] BLANK_T = TW'(BLANK_CYCLES);
    localparam logic [IW-1:0] LAST_I  = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                  state, state_n;
    logic [TW-1:0]           timer, timer_n;
    logic [IW-1:0]           idx, idx_n;
    logic [4*NUM_DIGITS-1:0] buffer, shadow;
    logic                    pending, frame_end, commit, xfer, blank_digit, show;
    logic [3:0]              cur;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   sel_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    // Disabled cycles also count as commit points so a dark display never strands an update.
    assign pending   = !upd_ready;
    assign frame_end = en && timer == LAST_T && idx == LAST_I;
    assign commit    = pending && (frame_end || !en);
    assign xfer      = upd_valid && upd_ready;
    assign cur       = buffer[{idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
            idx   <= '0;
            state <= BLANK;
        end else begin
            timer <= timer_n;
            idx   <= idx_n;
            state <= state_n;
        end
    end

    always_comb begin
        timer_n = (!en || timer == LAST_T) ? '0 : timer + 1'b1;
        idx_n   = !en ? '0 : timer != LAST_T ? idx : idx == LAST_I ? '0 : idx + 1'b1;
        state_n = timer_n < BLANK_T ? BLANK : SHOW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            buffer    <= '0;
            upd_ready <= 1'b1;
        end else if (xfer) begin
            shadow    <= bcd_in;
            upd_ready <= 1'b0;
        end else if (commit) begin
            buffer    <= shadow;
            upd_ready <= 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_run;

    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run     = zero_run && buffer[4*k +: 4] == 4'd0;
            lead_zero[k] = zero_run;
        end
    end

    assign blank_digit = lead_zero[idx];
`else
    assign blank_digit = 1'b0;
`endif

    always_comb begin
        show  = en && state == SHOW;
        sel_d = show ? NUM_DIGITS'(1) << idx : '0;
        seg_d = (show && !blank_digit) ? decode(cur) : 7'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= '0;
            digit_sel  <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= seg_d;
            digit_sel  <= sel_d;
            frame_tick <= frame_end;
        end
    end
endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb_seg_scan_scheduler: directed bench for seg_scan_scheduler with PRESCALE=8, BLANK_CYCLES=2, NUM_DIGITS=3.
module tb_seg_scan_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [11:0] bcd_in = '0;
    logic [6:0]  seg_out;
    logic [2:0]  digit_sel;
    logic        frame_tick;
    int          checks = 0;
    int          failures = 0;
    int          ph = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z = 7'h00;
`else
    localparam logic [6:0] Z = 7'h3F;
`endif

    seg_scan_scheduler #(.NUM_DIGITS(3), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .bcd_in(bcd_in), .seg_out(seg_out), .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s ph=%0d observed=%0h expected=%0h", tag, ph, obs, exp);
        end
    endtask

    // ph counts edges since the scan (re)started; the outputs after edge ph show slot time ph-1.
    task automatic run(input int n, input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2);
        for (int i = 0; i < n; i++) begin
            int t, d;
            @(posedge clk);
            #1;
            ph++;
            t = (ph - 1) % 8;
            d = ((ph - 1) / 8) % 3;
            chk("digit_sel", 32'(digit_sel), t < 2 ? 0 : 32'(1) << d);
            chk("seg_out", 32'(seg_out), t < 2 ? 0 : 32'(d == 0 ? g0 : d == 1 ? g1 : g2));
            chk("frame_tick", 32'(frame_tick), 32'(ph % 24 == 0));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 32'(seg_out), 0);
        chk("rst_sel", 32'(digit_sel), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        chk("rst_ready", 32'(upd_ready), 1);
        rst_n = 1'b1;
        ph = 0;
        run(48, 7'h3F, Z, Z);
        run(4, 7'h3F, Z, Z);
        upd_valid = 1'b1;
        bcd_in = 12'h321;
        run(1, 7'h3F, Z, Z);
        upd_valid = 1'b0;
        chk("ready_low_321", 32'(upd_ready), 0);
        run(19, 7'h3F, Z, Z);
        chk("ready_back_321", 32'(upd_ready), 1);
        run(4, 7'h06, 7'h5B, 7'h4F);
        upd_valid = 1'b1;
        bcd_in = 12'h456;
        run(1, 7'h06, 7'h5B, 7'h4F);
        chk("ready_low_456", 32'(upd_ready), 0);
        bcd_in = 12'h999;
        run(19, 7'h06, 7'h5B, 7'h4F);
        chk("ready_back_456", 32'(upd_ready), 1);
        run(1, 7'h7D, 7'h6D, 7'h66);
        chk("ready_low_999", 32'(upd_ready), 0);
        upd_valid = 1'b0;
        run(23, 7'h7D, 7'h6D, 7'h66);
        run(24, 7'h6F, 7'h6F, 7'h6F);
        upd_valid = 1'b1;
        bcd_in = 12'h0A5;
        run(1, 7'h6F, 7'h6F, 7'h6F);
        upd_valid = 1'b0;
        run(23, 7'h6F, 7'h6F, 7'h6F);
        run(24, 7'h6D, 7'h00, Z);
        run(12, 7'h6D, 7'h00, Z);
        chk("sel_d1_before_en", 32'(digit_sel), 32'h2);
        en = 1'b0;
        upd_valid = 1'b1;
        bcd_in = 12'h987;
        @(posedge clk);
        #1;
        chk("en0_sel", 32'(digit_sel), 0);
        chk("en0_seg", 32'(seg_out), 0);
        chk("en0_ready", 32'(upd_ready), 0);
        upd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("en0_commit_ready", 32'(upd_ready), 1);
        chk("en0_tick", 32'(frame_tick), 0);
        @(posedge clk);
        #1;
        chk("en0_sel2", 32'(digit_sel), 0);
        en = 1'b1;
        ph = 0;
        run(24, 7'h07, 7'h7F, 7'h6F);
        run(2, 7'h07, 7'h7F, 7'h6F);
        upd_valid = 1'b1;
        bcd_in = 12'h111;
        run(1, 7'h07, 7'h7F, 7'h6F);
        upd_valid = 1'b0;
        chk("ready_low_111", 32'(upd_ready), 0);
        run(2, 7'h07, 7'h7F, 7'h6F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(digit_sel), 0);
        chk("arst_seg", 32'(seg_out), 0);
        chk("arst_ready", 32'(upd_ready), 1);
        chk("arst_tick", 32'(frame_tick), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ph = 0;
        run(48, 7'h3F, Z, Z);
        upd_valid = 1'b1;
        bcd_in = 12'h005;
        run(1, 7'h3F, Z, Z);
        upd_valid = 1'b0;
        run(23, 7'h3F, Z, Z);
        run(24, 7'h6D, Z, Z);
        upd_valid = 1'b1;
        bcd_in = 12'h105;
        run(1, 7'h6D, Z, Z);
        upd_valid = 1'b0;
        run(23, 7'h6D, Z, Z);
        run(24, 7'h6D, 7'h3F, 7'h06);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
